mmu_ctx_loader: RTL

//  Context-switch sequencer for the paged MMU: on start, walks a 4*NMMU-word map table in memory and

---
 rtl/mmu_ctx_loader_pkg.sv | 28 ++
 rtl/mmu_ctx_loader.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mmu_ctx_loader_pkg.sv
// Shared types and field positions for the MMU context loader.
//  state_t        : loader sequencer states
//  FLT_* / ENT_*  : bit positions inside the MMU register-port word
package mmu_ctx_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSave,
        StSel,
        StFetch,
        StWrite,
        StRestore
    } state_t;

    // Bit 0 of the MMU register word selects entry write (1) versus fault-register write (0).
    localparam int unsigned MMU_REG_ENTRY = 0;

    // Fault-register fields (also used as the entry-select word).
    localparam int unsigned FLT_VALID = 1;
    localparam int unsigned FLT_WRITE = 2;
    localparam int unsigned FLT_SUP   = 3;
    localparam int unsigned FLT_INS   = 4;

    // Page-entry fields.
    localparam int unsigned ENT_VALID     = 1;
    localparam int unsigned ENT_WRITEABLE = 2;

endpackage

// File: rtl/mmu_ctx_loader.sv
// Context-switch sequencer for the paged MMU. On start it saves the MMU fault register, then for
// every entry (ins/sup/user x NMMU pages) writes an entry-select word, fetches the table word from
// memory and writes it as the entry, and finally restores the saved fault register.
// Ports:
//  clk, reset          clock, synchronous active-high reset
//  start, base         begin a load from table base address (ignored while busy)
//  busy, done          loader active / one-cycle completion pulse
//  mem_req, mem_addr   memory read request (held until mem_ack), read address
//  mem_ack, mem_rdata  memory read completion and data
//  cpu_reg_write/data  core's MMU register write (always has priority on the MMU port)
//  mmu_reg_read        MMU fault register readback
//  mmu_reg_write/data  MMU register write port
module mmu_ctx_loader
    import mmu_ctx_loader_pkg::*;
#(
    parameter int unsigned RV   = 16,
    parameter int unsigned NMMU = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [RV-1:0] base,
    output logic          busy,
    output logic          done,
    output logic          mem_req,
    output logic [RV-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [RV-1:0] mem_rdata,
    input  logic          cpu_reg_write,
    input  logic [RV-1:0] cpu_reg_data,
    input  logic [RV-1:0] mmu_reg_read,
    output logic          mmu_reg_write,
    output logic [RV-1:0] mmu_reg_data
);

    localparam int unsigned NENT = 4 * NMMU;
    localparam int unsigned PB   = $clog2(NMMU);
    localparam int unsigned IW   = $clog2(NENT);
    localparam logic [IW-1:0] LAST_IDX = IW'(NENT - 1);

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_idx, w_idx_nxt;
    logic [RV-1:0]   r_base;
    logic [RV-1:0]   r_saved;
    logic [RV-1:0]   r_rdata;
    logic            r_done, w_done_nxt;

    logic            w_ld_write;
    logic [RV-1:0]   w_ld_data;
    logic [RV-1:0]   w_sel_word;
    logic [RV-1:0]   w_ent_word;
    logic [RV-1:0]   w_rst_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_base  <= '0;
            r_saved <= '0;
            r_rdata <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
            if (r_state == StIdle && start) begin
                r_base <= base;
            end
            if (r_state == StSave) begin
                r_saved <= mmu_reg_read;
            end
            if (r_state == StFetch && mem_ack) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    // Entry index layout: [PB-1:0] page, [PB] sup, [PB+1] ins.
    always_comb begin
        w_sel_word                = '0;
        w_sel_word[RV-1 -: PB]    = r_idx[PB-1:0];
        w_sel_word[FLT_SUP]       = r_idx[PB];
        w_sel_word[FLT_INS]       = r_idx[PB+1];
        w_sel_word[MMU_REG_ENTRY] = 1'b0;

        w_ent_word                = r_rdata;
        w_ent_word[MMU_REG_ENTRY] = 1'b1;

        w_rst_word                = r_saved;
        w_rst_word[MMU_REG_ENTRY] = 1'b0;
    end

    // A core write on the shared port stalls SEL/WRITE/RESTORE so the loader write is retried,
    // never dropped or duplicated.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        w_ld_write  = 1'b0;
        w_ld_data   = '0;
        mem_req     = 1'b0;
        mem_addr    = '0;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_nxt = StSave;
                    w_idx_nxt   = '0;
                end
            end
            StSave: begin
                w_state_nxt = StSel;
            end
            StSel: begin
                w_ld_write = 1'b1;
                w_ld_data  = w_sel_word;
                if (!cpu_reg_write) begin
                    w_state_nxt = StFetch;
                end
            end
            StFetch: begin
                mem_req  = 1'b1;
                mem_addr = r_base + RV'(r_idx);
                if (mem_ack) begin
                    w_state_nxt = StWrite;
                end
            end
            StWrite: begin
                w_ld_write = 1'b1;
                w_ld_data  = w_ent_word;
                if (!cpu_reg_write) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = StRestore;
                    end else begin
                        w_idx_nxt   = r_idx + IW'(1);
                        w_state_nxt = StSel;
                    end
                end
            end
            StRestore: begin
                w_ld_write = 1'b1;
                w_ld_data  = w_rst_word;
                if (!cpu_reg_write) begin
                    w_state_nxt = StIdle;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_comb begin
        mmu_reg_write = cpu_reg_write | w_ld_write;
        mmu_reg_data  = (w_ld_write && !cpu_reg_write) ? w_ld_data : cpu_reg_data;
    end

    assign busy = (r_state != StIdle);
    assign done = r_done;

endmodule
